serial_word_receiver: RTL and testbench
=======================================

Name: serial_word_receiver

Overview:
- Deserialises a bit stream on an external serial clock / data / select interface into bitwidth-wide words.
- Emits each completed word with a one-cycle load_enable strobe, so it connects directly to the value_in/load_enable inputs of the downstream load-enabled register buffer.
- All external inputs are asynchronous to clock and are synchronised internally.

Parameters:
- bitwidth, 8, word width in bits; must be ≥ 2.
- msb_first, 1, 1 = first received bit lands in value_out[bitwidth-1]; 0 = first bit lands in value_out[0].

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- serial_clock  input  1  external serial clock; data is sampled on its rising edge. Asynchronous to clock.
- serial_data  input  1  external serial data. Asynchronous to clock.
- serial_select_n  input  1  active-low frame select. Asynchronous to clock.
- value_out  output  bitwidth  last completed word; held until the next word completes.
- load_enable  output  1  one-cycle strobe, high in the cycle value_out first presents a new word.
- busy  output  1  high while a frame is selected.
- frame_error  output  1  sticky flag: a frame ended with a partial word.

Behaviour:
- Interface: one clock (clock); reset is asynchronous and active-high (reset).
- Reset values: value_out=0, load_enable=0, busy=0, frame_error=0, bit counter=0, shift register=0, synchronisers=idle levels (serial_clock=0, serial_select_n=1, serial_data=0).
- Synchronisation:
  - Each of serial_clock, serial_data and serial_select_n passes through its own 2-flop synchroniser.
  - A third flop on the synchronised serial_clock gives its previous value.
  - rise = synchronised serial_clock high AND previous value low.
  - All decisions below use only synchronised signals.
- Timing requirement: serial_clock high and low phases each ≥ 3 clock periods. serial_data must be stable for ≥ 3 clock periods around each serial_clock rising edge.
- States:
  - IDLE: busy=0.
    - Synchronised select low → SHIFT; bit counter cleared, frame_error cleared, busy=1 from the next cycle.
    - A rise while in IDLE is ignored.
  - SHIFT, rise with counter < bitwidth-1: shift the synchronised data bit in (direction set by msb_first); counter increments.
  - SHIFT, rise with counter = bitwidth-1:
    - The assembled word including this bit is registered into value_out on the same clock edge.
    - load_enable=1 for exactly that following cycle.
    - Counter wraps to 0 and the state remains SHIFT, so back-to-back words in one frame are supported.
  - SHIFT, synchronised select high: → IDLE.
    - If counter ≠ 0, frame_error set to 1 and the partial word is discarded; value_out unchanged, no strobe.
    - If counter = 0, frame_error is unchanged.
  - Simultaneous rise and select deassertion in the same cycle: the rise is processed first (bit counted, word completes if it is the last bit), then → IDLE. frame_error is evaluated on the post-shift counter.
- Latency: a serial_clock rising edge first captured by sync flop 1 at clock edge k is acted upon at edge k+2. For the last bit of a word, value_out and load_enable are visible after edge k+2.
- load_enable is never high two consecutive cycles, given the timing requirement.
- frame_error stays set through IDLE until the next frame begins (select asserted) or reset.
- Reset mid-word: all state cleared immediately. No strobe is emitted for the partial word, and no error is flagged after release.

Test Plan:
- bitwidth=8, msb_first=1; select low; send 0xA5 MSB-first; select high → exactly one load_enable pulse, value_out=0xA5 from that cycle onward, frame_error=0, busy falls after select.
- One frame carrying 0x3C then 0xC3 back-to-back → two single-cycle pulses spaced 8 serial clocks apart; value_out=0x3C after the first, 0xC3 after the second.
- After 0x5A is received, new frame sends 5 bits then select high → no pulse, value_out stays 0x5A, frame_error=1. Next frame asserts select → frame_error=0; sending 0x81 → one pulse, value_out=0x81.
- msb_first=0; send bits 1,0,0,0,0,0,0,0 in time order → value_out=0x01.
- Assert reset after 4 bits of 0xFF, release, run a full 0x0F frame → outputs all 0 during reset; afterwards exactly one pulse with value_out=0x0F, frame_error=0.
- serial_clock toggles 8 times with select high → no pulse, busy=0, value_out unchanged.

Source files
------------

// File: rtl/serial_word_receiver.sv
// Serial clock/data/select receiver: synchronises the external interface into the
// clock domain and assembles bitwidth-wide words, strobing load_enable per word.
module serial_word_receiver #(
    parameter int bitwidth  = 8,
    parameter bit msb_first = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                serial_clock,
    input  logic                serial_data,
    input  logic                serial_select_n,
    output logic [bitwidth-1:0] value_out,
    output logic                load_enable,
    output logic                busy,
    output logic                frame_error
);

    localparam int CNT_W = (bitwidth > 2) ? $clog2(bitwidth) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(bitwidth - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t              state;
    logic                sclk_p0, sclk_p1, sclk_p2;
    logic                sdat_p0, sdat_p1;
    logic                ssel_p0, ssel_p1;
    logic [CNT_W-1:0]    bit_count;
    logic [bitwidth-1:0] shift_reg;

    logic                rise;
    logic                last_bit;
    logic [bitwidth-1:0] shifted;
    logic [CNT_W-1:0]    count_after;

    function automatic logic [bitwidth-1:0] shift_in(input logic [bitwidth-1:0] word,
                                                     input logic bit_in);
        if (msb_first)
            return {word[bitwidth-2:0], bit_in};
        else
            return {bit_in, word[bitwidth-1:1]};
    endfunction

    // Synchroniser stage: two flops per input, plus a history flop on serial_clock
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sclk_p0 <= 1'b0;
            sclk_p1 <= 1'b0;
            sclk_p2 <= 1'b0;
            sdat_p0 <= 1'b0;
            sdat_p1 <= 1'b0;
            ssel_p0 <= 1'b1;
            ssel_p1 <= 1'b1;
        end else begin
            sclk_p0 <= serial_clock;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
            sdat_p0 <= serial_data;
            sdat_p1 <= sdat_p0;
            ssel_p0 <= serial_select_n;
            ssel_p1 <= ssel_p0;
        end
    end

    always_comb begin
        rise        = sclk_p1 & ~sclk_p2;
        last_bit    = (bit_count == LAST_BIT);
        shifted     = shift_in(shift_reg, sdat_p1);
        count_after = bit_count;
        if (rise)
            count_after = last_bit ? '0 : bit_count + 1'b1;
    end

    // Frame stage: a rise in the same cycle as deselect is absorbed before the
    // frame closes, so the error test looks at the post-shift count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            bit_count   <= '0;
            shift_reg   <= '0;
            value_out   <= '0;
            load_enable <= 1'b0;
            busy        <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            load_enable <= 1'b0;
            case (state)
                IDLE: begin
                    if (!ssel_p1) begin
                        state       <= SHIFT;
                        bit_count   <= '0;
                        shift_reg   <= '0;
                        frame_error <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (rise) begin
                        shift_reg <= shifted;
                        bit_count <= count_after;
                        if (last_bit) begin
                            value_out   <= shifted;
                            load_enable <= 1'b1;
                        end
                    end
                    if (ssel_p1) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (count_after != '0)
                            frame_error <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_word_receiver.sv
// Scoreboard bench: one MSB-first and one LSB-first receiver share the serial bus;
// expected words come from chopping each frame's bit list into bytes.
module tb_serial_word_receiver;

    logic       clock = 1'b0;
    logic       reset;
    logic       serial_clock;
    logic       serial_data;
    logic       serial_select_n;
    logic [7:0] vo_m, vo_l;
    logic       le_m, le_l, busy_m, busy_l, fe_m, fe_l;

    serial_word_receiver #(.bitwidth(8), .msb_first(1'b1)) dut_msb (
        .clock(clock), .reset(reset), .serial_clock(serial_clock),
        .serial_data(serial_data), .serial_select_n(serial_select_n),
        .value_out(vo_m), .load_enable(le_m), .busy(busy_m), .frame_error(fe_m)
    );

    serial_word_receiver #(.bitwidth(8), .msb_first(1'b0)) dut_lsb (
        .clock(clock), .reset(reset), .serial_clock(serial_clock),
        .serial_data(serial_data), .serial_select_n(serial_select_n),
        .value_out(vo_l), .load_enable(le_l), .busy(busy_l), .frame_error(fe_l)
    );

    always #5 clock = ~clock;

    int         passed = 0;
    int         total = 0;
    logic [7:0] exp_m[$];
    logic [7:0] exp_l[$];
    bit         fbits[$];
    logic [7:0] last_m = 8'h00;
    logic [7:0] last_l = 8'h00;
    int         pulses_m = 0;
    int         pulses_l = 0;
    int         exp_pulses = 0;
    logic       prev_le_m = 1'b0;
    logic       prev_le_l = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    // Monitor: every strobe must match the oldest outstanding expected word
    always @(negedge clock) begin
        if (le_m) begin
            pulses_m++;
            check("msb_single_cycle_strobe", {31'd0, prev_le_m}, 32'd0);
            check("msb_word_expected", {31'd0, exp_m.size() > 0}, 32'd1);
            if (exp_m.size() > 0) check("msb_word", {24'd0, vo_m}, {24'd0, exp_m.pop_front()});
        end
        if (le_l) begin
            pulses_l++;
            check("lsb_single_cycle_strobe", {31'd0, prev_le_l}, 32'd0);
            check("lsb_word_expected", {31'd0, exp_l.size() > 0}, 32'd1);
            if (exp_l.size() > 0) check("lsb_word", {24'd0, vo_l}, {24'd0, exp_l.pop_front()});
        end
        prev_le_m = le_m;
        prev_le_l = le_l;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic send_bit(input bit b);
        serial_data = b;
        tick(3);
        serial_clock = 1'b1;
        tick(5);
        serial_clock = 1'b0;
        tick(2);
    endtask

    task automatic add_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) fbits.push_back(b[i]);
    endtask

    // Reference: every complete group of 8 bits in time order is one word
    task automatic model_frame();
        int n;
        logic [7:0] wm, wl;
        n = fbits.size();
        for (int w = 0; w < n / 8; w++) begin
            wm = 8'h00;
            wl = 8'h00;
            for (int i = 0; i < 8; i++) begin
                if (fbits[w*8+i]) begin
                    wm = wm | (8'h80 >> i);
                    wl = wl | (8'h01 << i);
                end
            end
            exp_m.push_back(wm);
            exp_l.push_back(wl);
            last_m = wm;
            last_l = wl;
        end
        exp_pulses += n / 8;
    endtask

    task automatic check_idle(input string tag, input bit exp_fe);
        check({tag, "_busy"}, {30'd0, busy_m, busy_l}, 32'd0);
        check({tag, "_frame_error"}, {30'd0, fe_m, fe_l}, {30'd0, exp_fe, exp_fe});
        check({tag, "_value_out"}, {16'd0, vo_m, vo_l}, {16'd0, last_m, last_l});
        check({tag, "_pulse_count"}, pulses_m + pulses_l, 2 * exp_pulses);
    endtask

    task automatic send_frame(input string tag);
        int n;
        n = fbits.size();
        model_frame();
        tick(1);
        serial_select_n = 1'b0;
        tick(5);
        check({tag, "_busy_in_frame"}, {30'd0, busy_m, busy_l}, 32'd3);
        check({tag, "_error_cleared"}, {30'd0, fe_m, fe_l}, 32'd0);
        for (int i = 0; i < n; i++) send_bit(fbits[i]);
        tick(3);
        serial_select_n = 1'b1;
        tick(8);
        check_idle(tag, (n % 8) != 0);
        fbits.delete();
    endtask

    initial begin
        reset = 1'b1;
        serial_clock = 1'b0;
        serial_data = 1'b0;
        serial_select_n = 1'b1;
        tick(3);
        check("reset_outputs", {12'd0, vo_m, vo_l, le_m, le_l, busy_m, busy_l}, 32'd0);
        check("reset_frame_error", {30'd0, fe_m, fe_l}, 32'd0);
        reset = 1'b0;
        tick(3);

        add_byte(8'hA5);
        send_frame("a5");
        add_byte(8'h3C);
        add_byte(8'hC3);
        send_frame("back_to_back");
        add_byte(8'h5A);
        send_frame("5a");
        for (int i = 0; i < 5; i++) fbits.push_back(1'b1);
        send_frame("partial");
        add_byte(8'h81);
        send_frame("81");
        add_byte(8'h80);
        send_frame("single_first_bit");

        // Reset in the middle of a word
        tick(1);
        serial_select_n = 1'b0;
        tick(5);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        #1 reset = 1'b1;
        #1 check("midword_reset_async", {12'd0, vo_m, vo_l, le_m, le_l, busy_m, busy_l}, 32'd0);
        serial_select_n = 1'b1;
        last_m = 8'h00;
        last_l = 8'h00;
        tick(4);
        check("midword_reset_held", {10'd0, vo_m, vo_l, le_m, le_l, busy_m, busy_l, fe_m, fe_l}, 32'd0);
        reset = 1'b0;
        tick(6);
        check_idle("after_reset", 1'b0);
        add_byte(8'h0F);
        send_frame("0f_after_reset");

        // Serial clock activity while deselected must be ignored
        for (int i = 0; i < 8; i++) send_bit(i[0]);
        tick(4);
        check_idle("deselected_clocks", 1'b0);

        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) fbits.push_back(bit'($urandom_range(0, 1)));
            send_frame("random");
        end

        tick(4);
        check("queues_drained", exp_m.size() + exp_l.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
